// File: rtl/ysyx_23060124_exu_lsu_regs_if.sv
// -----------------------------------------------------------------------------
// ysyx_23060124_exu_lsu_regs_if
//
// Purpose : groups the EXU->LSU pipeline-register handshake and payload
//           signals into one bundle so the stage register and its neighbours
//           connect through a single port.
//
// Modports:
//   slave  - the pipeline register itself: samples the i_* side (EXU beat,
//            LSU ready, flush) and drives the o_* side (ready to EXU, valid
//            and registered payload to LSU).
//   master - the environment around it (EXU + LSU, or a testbench): drives
//            i_* and observes o_*.
//
// Signals:
//   i_pre_valid / o_pre_ready   EXU-side valid/ready handshake
//   o_post_valid / i_post_ready LSU-side valid/ready handshake
//   i_flush                     redirect flush, discards held and offered beats
//   i_pc .. i_store_opt         EXU result beat
//   o_pc .. o_store_opt         registered beat presented to the LSU
// -----------------------------------------------------------------------------
interface ysyx_23060124_exu_lsu_regs_if;

  // Handshake and flush
  logic        i_pre_valid;
  logic        o_pre_ready;
  logic        o_post_valid;
  logic        i_post_ready;
  logic        i_flush;

  // Incoming EXU beat
  logic [31:0] i_pc;
  logic [31:0] i_alu_res;
  logic [31:0] i_lsu_wdata;
  logic [31:0] i_csr_wdata;
  logic [11:0] i_csr_addr;
  logic [4:0]  i_rd;
  logic        i_wen;
  logic        i_csr_wen;
  logic        i_load;
  logic        i_store;
  logic        i_ebreak;
  logic [2:0]  i_load_opt;
  logic [2:0]  i_store_opt;

  // Registered beat towards the LSU
  logic [31:0] o_pc;
  logic [31:0] o_alu_res;
  logic [31:0] o_lsu_wdata;
  logic [31:0] o_csr_wdata;
  logic [11:0] o_csr_addr;
  logic [4:0]  o_rd;
  logic        o_wen;
  logic        o_csr_wen;
  logic        o_load;
  logic        o_store;
  logic        o_ebreak;
  logic [2:0]  o_load_opt;
  logic [2:0]  o_store_opt;

  modport slave (
    input  i_pre_valid, i_post_ready, i_flush,
    input  i_pc, i_alu_res, i_lsu_wdata, i_csr_wdata, i_csr_addr, i_rd,
    input  i_wen, i_csr_wen, i_load, i_store, i_ebreak, i_load_opt, i_store_opt,
    output o_pre_ready, o_post_valid,
    output o_pc, o_alu_res, o_lsu_wdata, o_csr_wdata, o_csr_addr, o_rd,
    output o_wen, o_csr_wen, o_load, o_store, o_ebreak, o_load_opt, o_store_opt
  );

  modport master (
    output i_pre_valid, i_post_ready, i_flush,
    output i_pc, i_alu_res, i_lsu_wdata, i_csr_wdata, i_csr_addr, i_rd,
    output i_wen, i_csr_wen, i_load, i_store, i_ebreak, i_load_opt, i_store_opt,
    input  o_pre_ready, o_post_valid,
    input  o_pc, o_alu_res, o_lsu_wdata, o_csr_wdata, o_csr_addr, o_rd,
    input  o_wen, o_csr_wen, o_load, o_store, o_ebreak, o_load_opt, o_store_opt
  );

endinterface

// File: rtl/ysyx_23060124_exu_lsu_regs.sv
// -----------------------------------------------------------------------------
// ysyx_23060124_exu_lsu_regs
//
// Purpose : pipeline register between the execute stage (EXU) and the
//           load/store stage (LSU). Captures one EXU result beat under a
//           valid/ready handshake, presents it to the LSU, and discards every
//           in-flight beat on a redirect flush.
//
// Ports:
//   clock   - core clock, all state updates on the rising edge
//   reset   - synchronous, active-high
//   io_bus  - ysyx_23060124_exu_lsu_regs_if.slave: EXU handshake
//             (i_pre_valid/o_pre_ready), LSU handshake
//             (o_post_valid/i_post_ready), i_flush, and the i_*/o_* payload.
//
// Configuration macro:
//   EXU_LSU_SKID_EN - when defined, a second (skid) entry sits behind the
//                     main entry so o_pre_ready depends only on state and
//                     reset, cutting the combinational path from
//                     i_post_ready. When undefined the block is a single
//                     entry whose ready is (~main_v | i_post_ready) & ~reset.
//
// Behaviour common to both builds:
//   - priority per cycle: reset > flush > normal update
//   - a flush clears both valid bits and all o_* payload; an offered beat in
//     the flush cycle is dropped
//   - whenever the main entry empties without a replacement, the o_* payload
//     is zeroed so the LSU never observes stale control flags
// -----------------------------------------------------------------------------
module ysyx_23060124_exu_lsu_regs (
  input  logic                             clock,
  input  logic                             reset,
  ysyx_23060124_exu_lsu_regs_if.slave      io_bus
);

  // One EXU result beat, everything except handshake and flush.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] lsu_wdata;
    logic [31:0] csr_wdata;
    logic [11:0] csr_addr;
    logic [4:0]  rd;
    logic        wen;
    logic        csr_wen;
    logic        load;
    logic        store;
    logic        ebreak;
    logic [2:0]  load_opt;
    logic [2:0]  store_opt;
  } payload_t;

  payload_t w_in_beat;
  payload_t r_main;
  logic     r_main_v;
  logic     w_ready;
  logic     w_acc;
  logic     w_drn;

  assign w_in_beat = '{
    pc:        io_bus.i_pc,
    alu_res:   io_bus.i_alu_res,
    lsu_wdata: io_bus.i_lsu_wdata,
    csr_wdata: io_bus.i_csr_wdata,
    csr_addr:  io_bus.i_csr_addr,
    rd:        io_bus.i_rd,
    wen:       io_bus.i_wen,
    csr_wen:   io_bus.i_csr_wen,
    load:      io_bus.i_load,
    store:     io_bus.i_store,
    ebreak:    io_bus.i_ebreak,
    load_opt:  io_bus.i_load_opt,
    store_opt: io_bus.i_store_opt
  };

  // A beat offered during a flush is never accepted, even with ready high.
  assign w_acc = io_bus.i_pre_valid & w_ready & ~io_bus.i_flush;
  assign w_drn = r_main_v & io_bus.i_post_ready;

`ifdef EXU_LSU_SKID_EN

  payload_t r_skid;
  logic     r_skid_v;

  // Ready comes only from state and reset: no path from i_post_ready.
  assign w_ready = ~r_skid_v & ~reset;

  always_ff @(posedge clock) begin
    // NOTE: every state element in a clocked block uses <=, so all
    // registers see the pre-edge values of each other regardless of order.
    if (reset) begin
      // NOTE: the payload registers are reset along with the valid bits
      // because the o_* ports must read as 0 out of reset, not just be
      // qualified by o_post_valid.
      r_main_v <= 1'b0;
      r_main   <= '0;
      r_skid_v <= 1'b0;
      r_skid   <= '0;
    end else if (io_bus.i_flush) begin
      r_main_v <= 1'b0;
      r_main   <= '0;
      r_skid_v <= 1'b0;
      r_skid   <= '0;
    end else if (!r_main_v || w_drn) begin
      // Main is free this edge. The skid beat is older than anything on
      // the input, so it moves first; ready is low while skid is full, so
      // no new beat can arrive in the same cycle.
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
        r_skid   <= '0;
      end else if (w_acc) begin
        r_main   <= w_in_beat;
        r_main_v <= 1'b1;
      end else if (w_drn) begin
        // Main empties with nothing behind it: zero the visible payload.
        r_main_v <= 1'b0;
        r_main   <= '0;
      end
    end else if (w_acc) begin
      // Main is stalled: park the new beat in skid, main holds.
      r_skid   <= w_in_beat;
      r_skid_v <= 1'b1;
    end
  end

`else

  // Single entry: accept when empty or when the held beat leaves this edge.
  assign w_ready = (~r_main_v | io_bus.i_post_ready) & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_main_v <= 1'b0;
      r_main   <= '0;
    end else if (io_bus.i_flush) begin
      r_main_v <= 1'b0;
      r_main   <= '0;
    end else if (w_acc) begin
      r_main   <= w_in_beat;
      r_main_v <= 1'b1;
    end else if (w_drn) begin
      r_main_v <= 1'b0;
      r_main   <= '0;
    end
  end

`endif

  assign io_bus.o_pre_ready  = w_ready;
  assign io_bus.o_post_valid = r_main_v;

  assign io_bus.o_pc         = r_main.pc;
  assign io_bus.o_alu_res    = r_main.alu_res;
  assign io_bus.o_lsu_wdata  = r_main.lsu_wdata;
  assign io_bus.o_csr_wdata  = r_main.csr_wdata;
  assign io_bus.o_csr_addr   = r_main.csr_addr;
  assign io_bus.o_rd         = r_main.rd;
  assign io_bus.o_wen        = r_main.wen;
  assign io_bus.o_csr_wen    = r_main.csr_wen;
  assign io_bus.o_load       = r_main.load;
  assign io_bus.o_store      = r_main.store;
  assign io_bus.o_ebreak     = r_main.ebreak;
  assign io_bus.o_load_opt   = r_main.load_opt;
  assign io_bus.o_store_opt  = r_main.store_opt;

endmodule
